// File: rtl/pit_axi_regs.sv
// AXI4-Lite register block for a programmable interval timer: CTRL, PERIOD, STATUS, COUNT.
// Define PIT_REGS_COUNT_RD_EN to make reads of COUNT (0xC) return the live count input.
module pit_axi_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                            aclk,
   input  logic                            areset,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [2:0]                      s_axi_awprot,
   input  logic                            s_axi_awvalid,
   output logic                            s_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                            s_axi_wvalid,
   output logic                            s_axi_wready,
   output logic [1:0]                      s_axi_bresp,
   output logic                            s_axi_bvalid,
   input  logic                            s_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [2:0]                      s_axi_arprot,
   input  logic                            s_axi_arvalid,
   output logic                            s_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]                      s_axi_rresp,
   output logic                            s_axi_rvalid,
   input  logic                            s_axi_rready,
   output logic                            run,
   output logic                            reload,
   output logic [31:0]                     period,
   output logic                            period_load,
   input  logic                            tick,
   input  logic [31:0]                     count,
   output logic                            irq
);

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_PERIOD = 2'd1;
   localparam logic [1:0] A_STATUS = 2'd2;
   localparam logic [1:0] A_COUNT  = 2'd3;

   typedef enum logic [1:0] {WIDLE, WACK, WRESP} wstate_t;
   typedef enum logic [1:0] {RIDLE, RACK, RDATA} rstate_t;

   wstate_t     wstate;
   rstate_t     rstate;
   logic        irq_en;
   logic        pending;
   logic        pending_nxt;
   logic        irq_en_nxt;
   logic        wr_commit;
   logic [1:0]  wr_off;
   logic [1:0]  rd_off_q;
   logic [31:0] rd_val;
   logic        unused_ok;

   function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++)
         if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
      return res;
   endfunction

   // The master holds address and data through the WACK cycle, so commit straight from the bus.
   assign wr_commit = (wstate == WACK);
   assign wr_off    = s_axi_awaddr[3:2];

   always_ff @(posedge aclk) begin
      if (areset) begin
         wstate        <= WIDLE;
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         s_axi_bresp   <= 2'b00;
      end else begin
         case (wstate)
            WIDLE: if (s_axi_awvalid && s_axi_wvalid) begin
               wstate        <= WACK;
               s_axi_awready <= 1'b1;
               s_axi_wready  <= 1'b1;
            end
            WACK: begin
               wstate        <= WRESP;
               s_axi_awready <= 1'b0;
               s_axi_wready  <= 1'b0;
               s_axi_bvalid  <= 1'b1;
               s_axi_bresp   <= 2'b00;
            end
            WRESP: if (s_axi_bready) begin
               wstate       <= WIDLE;
               s_axi_bvalid <= 1'b0;
            end
            default: begin
               wstate        <= WIDLE;
               s_axi_awready <= 1'b0;
               s_axi_wready  <= 1'b0;
               s_axi_bvalid  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      rd_val = '0;
      case (rd_off_q)
         A_CTRL:   rd_val = {30'd0, run, irq_en};
         A_PERIOD: rd_val = period;
         A_STATUS: rd_val = {31'd0, pending};
`ifdef PIT_REGS_COUNT_RD_EN
         A_COUNT:  rd_val = count;
`else
         A_COUNT:  rd_val = '0;
`endif
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         rstate        <= RIDLE;
         s_axi_arready <= 1'b0;
         s_axi_rvalid  <= 1'b0;
         s_axi_rresp   <= 2'b00;
         s_axi_rdata   <= '0;
      end else begin
         case (rstate)
            RIDLE: if (s_axi_arvalid) begin
               rstate        <= RACK;
               s_axi_arready <= 1'b1;
               rd_off_q      <= s_axi_araddr[3:2];
            end
            RACK: begin
               rstate        <= RDATA;
               s_axi_arready <= 1'b0;
               s_axi_rvalid  <= 1'b1;
               s_axi_rresp   <= 2'b00;
               s_axi_rdata   <= rd_val;
            end
            RDATA: if (s_axi_rready) begin
               rstate       <= RIDLE;
               s_axi_rvalid <= 1'b0;
            end
            default: begin
               rstate        <= RIDLE;
               s_axi_arready <= 1'b0;
               s_axi_rvalid  <= 1'b0;
            end
         endcase
      end
   end

   // Tick is applied after the clear so a coincident expiry keeps the interrupt pending.
   always_comb begin
      pending_nxt = pending;
      irq_en_nxt  = irq_en;
      if (wr_commit && wr_off == A_STATUS && s_axi_wdata[0]) pending_nxt = 1'b0;
      if (wr_commit && wr_off == A_CTRL && s_axi_wstrb[0])   irq_en_nxt  = s_axi_wdata[0];
      if (tick) pending_nxt = 1'b1;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         run         <= 1'b0;
         irq_en      <= 1'b0;
         pending     <= 1'b0;
         irq         <= 1'b0;
         reload      <= 1'b0;
         period_load <= 1'b0;
         period      <= '0;
      end else begin
         pending     <= pending_nxt;
         irq_en      <= irq_en_nxt;
         irq         <= pending_nxt & irq_en_nxt;
         reload      <= 1'b0;
         period_load <= 1'b0;
         if (wr_commit) begin
            case (wr_off)
               A_CTRL: if (s_axi_wstrb[0]) begin
                  run    <= s_axi_wdata[1];
                  reload <= s_axi_wdata[3];
               end
               A_PERIOD: begin
                  period      <= apply_strb(period, s_axi_wdata, s_axi_wstrb);
                  period_load <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef PIT_REGS_COUNT_RD_EN
   assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};
`else
   assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0], count};
`endif

endmodule

// File: tb/tb_pit_axi_regs.sv
// Self-checking bench for pit_axi_regs: AXI4-Lite writes/reads with a read-data scoreboard queue.
module tb_pit_axi_regs;

   logic        aclk = 1'b0;
   logic        areset;
   logic [3:0]  s_axi_awaddr;
   logic [2:0]  s_axi_awprot;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;
   logic [3:0]  s_axi_araddr;
   logic [2:0]  s_axi_arprot;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready;
   logic        run;
   logic        reload;
   logic [31:0] period;
   logic        period_load;
   logic        tick;
   logic [31:0] count;
   logic        irq;

   int          n_checks = 0;
   int          n_fail = 0;
   int          reload_cnt = 0;
   int          pl_cnt = 0;
   logic [31:0] exp_q[$];

   localparam logic [31:0] COUNT_VAL = 32'hCAFE_0123;

   pit_axi_regs dut (
      .aclk(aclk), .areset(areset),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .run(run), .reload(reload), .period(period), .period_load(period_load),
      .tick(tick), .count(count), .irq(irq)
   );

   always #5 aclk = ~aclk;

   always @(posedge aclk) begin
      if (reload)      reload_cnt <= reload_cnt + 1;
      if (period_load) pl_cnt     <= pl_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            input bit tick_at_commit, input string name);
      int cyc;
      @(posedge aclk); #1;
      s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
      cyc = 0;
      while (!s_axi_awready && cyc < 20) begin @(posedge aclk); #1; cyc++; end
      if (!s_axi_awready) begin
         n_checks++; n_fail++;
         $display("FAIL %s awready timeout: got %b expected 1", name, s_axi_awready);
         s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
         return;
      end
      if (tick_at_commit) tick = 1'b1;
      @(posedge aclk); #1;
      tick = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      n_checks++;
      if ({s_axi_bvalid, s_axi_bresp} !== 3'b100) begin
         n_fail++;
         $display("FAIL %s bresp: got bvalid=%b bresp=%b expected bvalid=1 bresp=00",
                  name, s_axi_bvalid, s_axi_bresp);
      end
      @(posedge aclk); #1;
      s_axi_bready = 1'b0;
   endtask

   task automatic axi_read(input logic [3:0] a, input logic [31:0] expv, input string name);
      int cyc;
      logic [31:0] e;
      exp_q.push_back(expv);
      @(posedge aclk); #1;
      s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
      cyc = 0;
      while (!s_axi_arready && cyc < 20) begin @(posedge aclk); #1; cyc++; end
      @(posedge aclk); #1;
      s_axi_arvalid = 1'b0;
      cyc = 0;
      while (!s_axi_rvalid && cyc < 20) begin @(posedge aclk); #1; cyc++; end
      e = exp_q.pop_front();
      n_checks++;
      if (!s_axi_rvalid) begin
         n_fail++;
         $display("FAIL %s rvalid timeout: got %b expected 1", name, s_axi_rvalid);
      end else if (s_axi_rdata !== e || s_axi_rresp !== 2'b00) begin
         n_fail++;
         $display("FAIL %s rdata: got %h rresp=%b expected %h rresp=00",
                  name, s_axi_rdata, s_axi_rresp, e);
      end
      @(posedge aclk); #1;
      s_axi_rready = 1'b0;
   endtask

   task automatic test_reset();
      areset = 1'b1;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
      s_axi_awaddr = 4'h4; s_axi_wdata = 32'h1234; s_axi_araddr = 4'h4;
      idle(3);
      n_checks++;
      if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid,
           run, reload, period_load, irq} !== 9'd0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 000000000",
                  {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid,
                   run, reload, period_load, irq});
      end
      n_checks++;
      if (period !== 32'h0) begin
         n_fail++; $display("FAIL reset_period: got %h expected 00000000", period);
      end
      n_checks++;
      if ({s_axi_bresp, s_axi_rresp} !== 4'd0 || s_axi_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_resp: got bresp=%b rresp=%b rdata=%h expected 00/00/00000000",
                  s_axi_bresp, s_axi_rresp, s_axi_rdata);
      end
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      areset = 1'b0;
      idle(1);
   endtask

   task automatic test_period();
      int pl0;
      pl0 = pl_cnt;
      axi_write(4'h4, 32'h3, 4'hF, 1'b0, "period_wr");
      idle(2);
      n_checks++;
      if (period !== 32'h3) begin
         n_fail++; $display("FAIL period_val: got %h expected 00000003", period);
      end
      n_checks++;
      if (pl_cnt - pl0 != 1) begin
         n_fail++; $display("FAIL period_load_pulses: got %0d expected 1", pl_cnt - pl0);
      end
      axi_read(4'h4, 32'h3, "period_rd");
   endtask

   task automatic test_ctrl();
      int r0;
      r0 = reload_cnt;
      axi_write(4'h0, 32'h2, 4'hF, 1'b0, "ctrl_run");
      n_checks++;
      if (run !== 1'b1) begin n_fail++; $display("FAIL ctrl_run1: got %b expected 1", run); end
      axi_write(4'h0, 32'h8, 4'hF, 1'b0, "ctrl_reload");
      idle(2);
      n_checks++;
      if (run !== 1'b0 || reload_cnt - r0 != 1) begin
         n_fail++;
         $display("FAIL ctrl_reload: got run=%b pulses=%0d expected run=0 pulses=1",
                  run, reload_cnt - r0);
      end
      axi_read(4'h0, 32'h0, "ctrl_rd_reload");
      axi_write(4'h0, 32'h2, 4'hF, 1'b0, "ctrl_run_again");
      n_checks++;
      if (run !== 1'b1) begin n_fail++; $display("FAIL ctrl_run2: got %b expected 1", run); end
      axi_write(4'h0, 32'h0, 4'h0, 1'b0, "ctrl_nostrb");
      n_checks++;
      if (run !== 1'b1) begin n_fail++; $display("FAIL ctrl_strb0: got %b expected 1", run); end
      axi_read(4'h0, 32'h2, "ctrl_rd");
   endtask

   task automatic test_irq();
      axi_write(4'h0, 32'h3, 4'hF, 1'b0, "irq_en");
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b expected 0", irq); end
      tick = 1'b1;
      @(posedge aclk); #1;
      tick = 1'b0;
      n_checks++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_tick: got %b expected 1", irq); end
      axi_read(4'h8, 32'h1, "status_pending");
      axi_write(4'h8, 32'h1, 4'hF, 1'b0, "status_clr");
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b expected 0", irq); end
      tick = 1'b1;
      @(posedge aclk); #1;
      tick = 1'b0;
      axi_write(4'h8, 32'h1, 4'hF, 1'b1, "status_clr_tick");
      n_checks++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins: got %b expected 1", irq); end
      axi_read(4'h8, 32'h1, "status_set_wins");
      axi_write(4'h8, 32'h1, 4'hF, 1'b0, "status_clr2");
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear2: got %b expected 0", irq); end
   endtask

   task automatic test_strobe();
      axi_write(4'h4, 32'hFFFF_FFFF, 4'hF, 1'b0, "period_ones");
      n_checks++;
      if (period !== 32'hFFFF_FFFF) begin
         n_fail++; $display("FAIL strobe_full: got %h expected ffffffff", period);
      end
      axi_write(4'h4, 32'h0000_00AA, 4'h1, 1'b0, "period_lane0");
      n_checks++;
      if (period !== 32'hFFFF_FFAA) begin
         n_fail++; $display("FAIL strobe_lane0: got %h expected ffffffaa", period);
      end
      axi_read(4'h4, 32'hFFFF_FFAA, "strobe_rd");
   endtask

   task automatic test_handshake();
      int cyc;
      @(posedge aclk); #1;
      s_axi_awaddr = 4'h4; s_axi_wdata = 32'h7; s_axi_wstrb = 4'hF;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge aclk); #1;
         n_checks++;
         if (s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) begin
            n_fail++;
            $display("FAIL aw_only_%0d: got awready=%b wready=%b expected 0/0",
                     i, s_axi_awready, s_axi_wready);
         end
      end
      s_axi_wvalid = 1'b1;
      cyc = 0;
      while (!s_axi_awready && cyc < 20) begin @(posedge aclk); #1; cyc++; end
      @(posedge aclk); #1;
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00) begin
            n_fail++;
            $display("FAIL bvalid_hold_%0d: got bvalid=%b bresp=%b expected 1/00",
                     i, s_axi_bvalid, s_axi_bresp);
         end
         @(posedge aclk); #1;
      end
      s_axi_bready = 1'b1;
      @(posedge aclk); #1;
      s_axi_bready = 1'b0;
      n_checks++;
      if (s_axi_bvalid !== 1'b0 || period !== 32'h7) begin
         n_fail++;
         $display("FAIL handshake_done: got bvalid=%b period=%h expected 0/00000007",
                  s_axi_bvalid, period);
      end
   endtask

   task automatic test_simultaneous();
      int cyc;
      logic [31:0] e;
      axi_write(4'h4, 32'h55, 4'hF, 1'b0, "sim_pre");
      exp_q.push_back(32'h55);
      @(posedge aclk); #1;
      s_axi_awaddr = 4'h4; s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'hF;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
      s_axi_araddr = 4'h4; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
      cyc = 0;
      while (!(s_axi_awready && s_axi_arready) && cyc < 20) begin @(posedge aclk); #1; cyc++; end
      @(posedge aclk); #1;
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== e) begin
         n_fail++;
         $display("FAIL sim_rd_old: got rvalid=%b rdata=%h expected 1/%h", s_axi_rvalid, s_axi_rdata, e);
      end
      n_checks++;
      if (s_axi_bvalid !== 1'b1 || period !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL sim_wr: got bvalid=%b period=%h expected 1/12345678", s_axi_bvalid, period);
      end
      @(posedge aclk); #1;
      s_axi_bready = 1'b0; s_axi_rready = 1'b0;
   endtask

   task automatic test_count();
      logic [31:0] ec;
`ifdef PIT_REGS_COUNT_RD_EN
      ec = COUNT_VAL;
`else
      ec = 32'h0;
`endif
      axi_write(4'hC, 32'hDEAD_BEEF, 4'hF, 1'b0, "count_wr");
      n_checks++;
      if (period !== 32'h1234_5678 || run !== 1'b1) begin
         n_fail++;
         $display("FAIL count_wr_effect: got period=%h run=%b expected 12345678/1", period, run);
      end
      axi_read(4'hC, ec, "count_rd");
   endtask

   task automatic test_reset_mid();
      int cyc;
      tick = 1'b1;
      @(posedge aclk); #1;
      tick = 1'b0;
      n_checks++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b expected 1", irq); end
      s_axi_awaddr = 4'h4; s_axi_wdata = 32'h99; s_axi_wstrb = 4'hF;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
      s_axi_araddr = 4'h8; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
      cyc = 0;
      while (!(s_axi_awready && s_axi_arready) && cyc < 20) begin @(posedge aclk); #1; cyc++; end
      @(posedge aclk); #1;
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      idle(1);
      n_checks++;
      if (s_axi_bvalid !== 1'b1 || s_axi_rvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_pending: got bvalid=%b rvalid=%b expected 1/1", s_axi_bvalid, s_axi_rvalid);
      end
      areset = 1'b1;
      @(posedge aclk); #1;
      n_checks++;
      if ({s_axi_bvalid, s_axi_rvalid, irq, run} !== 4'd0 || period !== 32'h0 ||
          s_axi_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL mid_reset: got bvalid=%b rvalid=%b irq=%b run=%b period=%h rdata=%h expected all 0",
                  s_axi_bvalid, s_axi_rvalid, irq, run, period, s_axi_rdata);
      end
      areset = 1'b0;
      idle(1);
      axi_read(4'h8, 32'h0, "status_after_reset");
      axi_read(4'h0, 32'h0, "ctrl_after_reset");
   endtask

   initial begin
      areset = 1'b1;
      s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
      s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
      s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
      tick = 1'b0;
      count = COUNT_VAL;
      test_reset();
      test_period();
      test_ctrl();
      test_irq();
      test_strobe();
      test_handshake();
      test_simultaneous();
      test_count();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pit_axi_regs.md
PIT_AXI_REGS -- requirements
Module: pit_axi_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte-address width; register offset = addr[3:2].
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have ports, in order:
- aclk  in  1  clock.
- areset  in  1  synchronous active-high reset.
- s_axi_awaddr/awprot/awvalid/awready  in/in/in/out  4/3/1/1  write address channel.
- s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- s_axi_araddr/arprot/arvalid/arready  in/in/in/out  4/3/1/1  read address channel.
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
- run  out  1  timer run enable to the downstream timer core.
- reload  out  1  one-cycle reload strobe to the timer core.
- period  out  32  timer period value.
- period_load  out  1  one-cycle strobe after a period write.
- tick  in  1  one-cycle expiry pulse from the timer core.
- count  in  32  live counter value from the timer core.
- irq  out  1  level interrupt.

Function
REQ-005 SHALL decode these registers: 0x0 CTRL (bit0 irq_en, bit1 run, bit3 reload), 0x4 PERIOD, 0x8 STATUS (bit0 pending, write-1-to-clear), 0xC COUNT (read-only).
REQ-006 SHALL implement the write FSM as follows:
- WIDLE -> WACK when awvalid && wvalid: awready and wready high for exactly one cycle; register commit in that cycle.
- WACK -> WRESP: bvalid high, bresp=00, held until bready.
- WRESP -> WIDLE on bvalid && bready.
REQ-007 SHALL NOT accept a write when only one of awvalid or wvalid is high; awready and wready SHALL stay low.
REQ-008 SHALL implement the read FSM as follows:
- RIDLE -> RACK when arvalid: arready high one cycle, address captured.
- RACK -> RDATA: rvalid high, rresp=00, rdata stable until rready.
- RDATA -> RIDLE on rvalid && rready.
REQ-009 SHALL apply wstrb per byte to CTRL and PERIOD; byte lanes with strobe 0 SHALL be unchanged.
REQ-010 SHALL, on a CTRL write with wdata[3]=1 and wstrb[0]=1, pulse reload high for exactly one cycle, the cycle after commit; CTRL bit3 SHALL read back 0.
REQ-011 SHALL pulse period_load for one cycle, the cycle after any PERIOD commit; period updates in the commit cycle.
REQ-012 SHALL set pending on tick; a STATUS write with wdata[0]=1 SHALL clear pending; tick in the same cycle as the clear SHALL leave pending=1 (set wins).
REQ-013 SHALL drive irq = pending && irq_en as a registered output, with one cycle of latency from tick.
REQ-014 SHALL accept writes to COUNT with OKAY response and no effect.
REQ-015 SHALL run the read and write FSMs independently; a simultaneous read and write of the same register SHALL return the pre-write value.

Reset
REQ-016 SHALL, while areset is high, force both FSMs to their idle states and drive all ready, valid and strobe outputs, run, irq and pending to 0, and period to 0x0000_0000, including when reset lands mid-transaction.
REQ-017 SHALL drive bresp, rresp and rdata to 0 during reset.

Configuration
REQ-018 SHALL, with macro PIT_REGS_COUNT_RD_EN defined, return the count input, sampled in the RACK cycle, on reads of 0xC.
REQ-019 SHALL, without PIT_REGS_COUNT_RD_EN, read 0xC as 0x0000_0000 and leave the count input unused.

Verification
REQ-020 SHALL cover: write PERIOD=3, then read 0x4 -> rdata=0x0000_0003, period=3, one period_load pulse, bresp=00.
REQ-021 SHALL cover: write CTRL=0x2, then 0x8, then 0x2 -> run=1, then run=0 with one reload pulse, then run=1; CTRL reads back 0x2.
REQ-022 SHALL cover: CTRL=0x3, tick pulse -> irq=1 one cycle later; STATUS write 0x1 -> irq=0; a tick coincident with the clear leaves irq=1.
REQ-023 SHALL cover: PERIOD=0xFFFF_FFFF, then write 0x0000_00AA with wstrb=0001 -> period=0xFFFF_FFAA.
REQ-024 SHALL cover: awvalid only for 5 cycles then wvalid -> no awready until both are valid; bvalid held for 3 cycles while bready=0.
REQ-025 SHALL cover: areset asserted during WRESP and RDATA -> bvalid=rvalid=0 next cycle; STATUS reads 0 after release.
